// File: rtl/uart_pkt_pkg.sv
// Shared types and defaults for the UART packet controller slice.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    CMD  = 3'd1,
    LEN  = 3'd2,
    PAY  = 3'd3,
    CSUM = 3'd4,
    DISP = 3'd5,
    RESP = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_CSUM = 2'd1,
    ERR_LEN  = 2'd2,
    ERR_TMO  = 2'd3
  } err_e;

  localparam logic [7:0] DEF_SYNC = 8'hAA;
  localparam logic [7:0] DEF_ACK  = 8'h06;
  localparam logic [7:0] DEF_NAK  = 8'h15;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: MAX_LEN x 8 register array, one write port, registered read port.
module uart_pkt_buf #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned AW      = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [MAX_LEN];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i && (32'(waddr_i) < MAX_LEN)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Out-of-range reads return zero rather than aliasing into the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (32'(raddr_i) < MAX_LEN) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_pkt_ctrl.sv
// Packet framer/validator between uart_core bytes and the command consumer,
// answering each packet with a single ACK or NAK byte.
module uart_pkt_ctrl
  import uart_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 64,
  parameter logic [7:0]  SYNC_BYTE = DEF_SYNC,
  parameter logic [7:0]  ACK_BYTE  = DEF_ACK,
  parameter logic [7:0]  NAK_BYTE  = DEF_NAK,
  parameter int unsigned TMO_CYC   = 100000
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_op,
  output logic [6:0] cmd_len,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [1:0] last_err,
  output logic       rx_drop
);

  localparam int unsigned TW = $clog2(TMO_CYC + 1);

  state_e        state_q, state_d;
  err_e          err_q,   err_d;
  logic [7:0]    sum_q,   sum_d;
  logic [6:0]    idx_q,   idx_d;
  logic [TW-1:0] tmo_q,   tmo_d;
  logic [7:0]    op_q,    op_d;
  logic [6:0]    len_q,   len_d;
  logic [7:0]    txd_q,   txd_d;
  logic          txv_q,   txv_d;
  logic          cv_q,    cv_d;
  logic          drop_q,  drop_d;
  logic          buf_we;
  logic          in_pkt;

  assign in_pkt = (state_q == CMD) || (state_q == LEN) ||
                  (state_q == PAY) || (state_q == CSUM);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    op_d    = op_q;
    len_d   = len_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    cv_d    = cv_q;
    drop_d  = 1'b0;
    buf_we  = 1'b0;
    tmo_d   = '0;

    if (in_pkt && !rx_valid) begin
      tmo_d = tmo_q + TW'(1);
    end

    unique case (state_q)
      HUNT: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          sum_d   = SYNC_BYTE;
          state_d = CMD;
        end
      end
      CMD: begin
        if (rx_valid) begin
          op_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = LEN;
        end
      end
      LEN: begin
        if (rx_valid) begin
          if (32'(rx_data) > MAX_LEN) begin
            err_d   = ERR_LEN;
            txd_d   = NAK_BYTE;
            txv_d   = 1'b1;
            state_d = RESP;
          end else begin
            len_d   = rx_data[6:0];
            sum_d   = sum_q + rx_data;
            idx_d   = '0;
            state_d = (rx_data == 8'd0) ? CSUM : PAY;
          end
        end
      end
      PAY: begin
        if (rx_valid) begin
          buf_we = 1'b1;
          sum_d  = sum_q + rx_data;
          idx_d  = idx_q + 7'd1;
          if ((idx_q + 7'd1) == len_q) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (rx_data == sum_q) begin
            err_d   = ERR_NONE;
            cv_d    = 1'b1;
            state_d = DISP;
          end else begin
            err_d   = ERR_CSUM;
            txd_d   = NAK_BYTE;
            txv_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      DISP: begin
        drop_d = rx_valid;
        if (cv_q && cmd_ready) begin
          cv_d    = 1'b0;
          txd_d   = ACK_BYTE;
          txv_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        drop_d = rx_valid;
        if (txv_q && tx_ready) begin
          txv_d   = 1'b0;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase

    // A byte landing on the terminal count takes priority over the timeout.
    if (in_pkt && !rx_valid && (tmo_q == TW'(TMO_CYC))) begin
      err_d   = ERR_TMO;
      txd_d   = NAK_BYTE;
      txv_d   = 1'b1;
      tmo_d   = '0;
      state_d = RESP;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      err_q   <= ERR_NONE;
      sum_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      op_q    <= '0;
      len_q   <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      cv_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      op_q    <= op_d;
      len_q   <= len_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      cv_q    <= cv_d;
      drop_q  <= drop_d;
    end
  end

  uart_pkt_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (6)
  ) u_buf (
    .clk     (CLK),
    .rst_n   (rst_n),
    .we_i    (buf_we),
    .waddr_i (idx_q[5:0]),
    .wdata_i (rx_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign tx_data   = txd_q;
  assign tx_valid  = txv_q;
  assign cmd_valid = cv_q;
  assign cmd_op    = op_q;
  assign cmd_len   = len_q;
  assign last_err  = err_q;
  assign rx_drop   = drop_q;

endmodule

// File: doc/uart_pkt_ctrl.md
Name: uart_pkt_ctrl

Overview:
Packet-level controller sitting between uart_core's byte interface and the MiniGPU command logic.
- Frames the raw rx byte stream into packets: SYNC, CMD, LEN, payload[LEN], CSUM.
- Validates each packet, buffers its payload and hands the command to a downstream consumer over a valid/ready handshake.
- Answers the host with a one-byte ACK or NAK through uart_core's tx handshake.

Parameters:
MAX_LEN, 64, payload buffer depth in bytes; legal LEN is 0..MAX_LEN.
SYNC_BYTE, 8'hAA, start-of-packet marker.
ACK_BYTE, 8'h06, response for a good packet.
NAK_BYTE, 8'h15, response for a rejected packet.
TMO_CYC, 100000, inter-byte timeout in CLK cycles while inside a packet.

Ports:
CLK  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  byte from uart_core
rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
tx_data  out  8  response byte to uart_core
tx_valid  out  1  response byte request
tx_ready  in  1  uart_core can accept a byte
cmd_valid  out  1  a validated packet is available
cmd_ready  in  1  consumer accepts the packet
cmd_op  out  8  CMD field of the packet
cmd_len  out  7  LEN field (0..MAX_LEN)
rd_addr  in  6  payload read index
rd_data  out  8  payload[rd_addr], 1-cycle registered latency
last_err  out  2  0 = none, 1 = CSUM, 2 = LEN, 3 = TMO; updated per packet
rx_drop  out  1  one-cycle pulse when an rx byte arrives outside HUNT..CSUM

Behaviour:
- Reset is asynchronous and active-low; it is the only reset. On reset:
  - state = HUNT.
  - tx_valid, cmd_valid, rx_drop = 0.
  - tx_data, cmd_op, cmd_len, last_err = 0.
  - Running sum, byte index and timeout counter = 0.
  - Buffer contents are don't-care.
- Reset asserted mid-packet discards the packet. No response is sent.
- States:
  - HUNT: ignore every byte except SYNC_BYTE. On SYNC, sum = SYNC_BYTE and go to CMD.
  - CMD: capture cmd_op, add it to sum, go to LEN.
  - LEN: if LEN > MAX_LEN, set last_err = LEN and go to RESP with NAK. Otherwise capture cmd_len, add it to sum, clear the index, and go to PAY (LEN > 0) or CSUM (LEN = 0).
  - PAY: write the byte to buf[index], add it to sum, increment index. After byte LEN-1, go to CSUM.
  - CSUM: if the byte equals sum, set last_err = 0 and go to DISP. Otherwise set last_err = CSUM and go to RESP with NAK.
  - DISP: cmd_valid = 1. Hold cmd_op, cmd_len and the buffer stable. The handshake completes at the first rising edge where cmd_valid & cmd_ready; cmd_valid drops the next cycle, then go to RESP with ACK.
  - RESP: assert tx_valid with tx_data = ACK_BYTE or NAK_BYTE. The transfer occurs at the edge where tx_valid & tx_ready; tx_valid = 0 the next cycle, then go to HUNT.
- Checksum: 8-bit sum modulo 256 of SYNC, CMD, LEN and every payload byte. The carry is discarded.
- Timeout: the counter clears on every rx_valid and counts only in CMD, LEN, PAY and CSUM. When it reaches TMO_CYC, set last_err = TMO and go to RESP with NAK.
- A rx_valid arriving in the same cycle as the timeout terminal count wins: the byte is processed and the counter clears.
- rx_valid in DISP or RESP: the byte is dropped and rx_drop pulses. uart_core has no backpressure, so the host must wait for the response.
- rd_data = buf[rd_addr] registered every cycle, independent of state. Reads with rd_addr ≥ MAX_LEN return 0.
- Each packet produces exactly one response byte, except when reset intervenes.
- A SYNC_BYTE value inside CMD, LEN, PAY or CSUM is plain data.

Decomposition:
- Package uart_pkt_pkg holds:
  - the state enum (HUNT, CMD, LEN, PAY, CSUM, DISP, RESP);
  - the error codes ERR_NONE, ERR_CSUM, ERR_LEN, ERR_TMO;
  - default SYNC, ACK and NAK constants.
- Sub-module uart_pkt_buf: MAX_LEN×8 register array with one write port and a registered read port.
- The FSM, checksum and timeout counter stay in uart_pkt_ctrl.

Test Plan:
- Good packet: AA 01 10, payload 10..1F, CSUM 33, with cmd_ready tied 1 → cmd_valid for one cycle with cmd_op = 01 and cmd_len = 16. Reading rd_addr 0..15 returns 10..1F. tx byte 06. last_err = 0.
- Same packet with CSUM 34 → no cmd_valid, tx 15, last_err = 1.
- Zero-length packet AA 10 00 BA → dispatch with cmd_len = 0, tx 06.
- Length error: AA 02 41 (65) → immediate NAK 15, last_err = 2. A following good packet is parsed normally.
- Timeout: AA 01 then silence for TMO_CYC cycles → NAK 15, last_err = 3, return to HUNT.
- Garbage 00 FF 55 before a good packet → ignored. With cmd_ready held 0 for 500 cycles, cmd_valid stays high and a byte injected then pulses rx_drop. Asserting rst_n = 0 mid-PAY → HUNT, no tx byte.
